// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with double-buffered load.
// Ports: clk, rst, din/dp_in/blank_in/load in; load_ack, seg, dp, wela, slot_tick out.
// Optional macro SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     wela,
  output logic                  slot_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0] P_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] P_DEAD = DIV_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DIGITS - 1);

  localparam logic              SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
  localparam logic              DP_OFF  = SEG_INV;
  localparam logic [DIGITS-1:0] AN_OFF  =
    {DIGITS{AN_ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]    p_q, p_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] dsh_q, dsh_d;
  logic [DIGITS-1:0]   dpsh_q, dpsh_d;
  logic [DIGITS-1:0]   blsh_q, blsh_d;
  logic [3:0]          cval_q, cval_d;
  logic                cdp_q, cdp_d;
  logic                cblk_q, cblk_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   wela_q, wela_d;
  logic                ack_q, ack_d;
  logic                tick_q, tick_d;

  logic                wrap;
  logic                lit;
  logic [DIGITS-1:0]   lz;
  logic [DIGITS-1:0]   oh;
  logic [3:0]          sel_val;
  logic                sel_dp;
  logic                sel_blk;
`ifdef SEG_LZB_EN
  logic                hi_zero;
`endif

  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap   = (p_q == P_LAST);
    p_d    = wrap ? '0 : p_q + DIV_W'(1);
    idx_d  = idx_q;
    if (wrap)
      idx_d = (idx_q == I_LAST) ? '0 : idx_q + IDX_W'(1);

    dsh_d  = load ? din      : dsh_q;
    dpsh_d = load ? dp_in    : dpsh_q;
    blsh_d = load ? blank_in : blsh_q;
    ack_d  = load;
    tick_d = wrap;

    lz = '0;
`ifdef SEG_LZB_EN
    // Digit 0 is excluded so an all-zero value still shows "0".
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero & (dsh_q[4*i +: 4] == 4'h0);
      lz[i]   = hi_zero & ~dpsh_q[i];
    end
`endif

    sel_val = '0;
    sel_dp  = 1'b0;
    sel_blk = 1'b1;
    oh      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        sel_val = dsh_q[4*i +: 4];
        sel_dp  = dpsh_q[i];
        sel_blk = blsh_q[i] | lz[i];
        oh[i]   = 1'b1;
      end
    end

    // Shadow is sampled only when a new slot begins, so a slot
    // never mixes old and new data.
    cval_d = wrap ? sel_val : cval_q;
    cdp_d  = wrap ? sel_dp  : cdp_q;
    cblk_d = wrap ? sel_blk : cblk_q;

    // Outputs are built from next-state so they line up with p_q.
    lit    = (p_d >= P_DEAD) && !cblk_d;
    seg_d  = lit ? (hex7(cval_d) ^ SEG_OFF) : SEG_OFF;
    dp_d   = lit ? (cdp_d ^ SEG_INV) : DP_OFF;
    wela_d = lit ? (oh ^ AN_OFF) : AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      idx_q  <= '0;
      dsh_q  <= '0;
      dpsh_q <= '0;
      blsh_q <= '1;
      cval_q <= '0;
      cdp_q  <= 1'b0;
      cblk_q <= 1'b1;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      wela_q <= AN_OFF;
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      idx_q  <= idx_d;
      dsh_q  <= dsh_d;
      dpsh_q <= dpsh_d;
      blsh_q <= blsh_d;
      cval_q <= cval_d;
      cdp_q  <= cdp_d;
      cblk_q <= cblk_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      wela_q <= wela_d;
      ack_q  <= ack_d;
      tick_q <= tick_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign wela      = wela_q;
  assign load_ack  = ack_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver.
// Two instances: active-low (main) and active-high (polarity check).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;

  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [3:0]  wela_l, wela_h;
  logic        ack_l, ack_h;
  logic        tick_l, tick_h;

  int checks = 0;
  int errors = 0;
  int bidx = 0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                           7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_lo (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .load_ack(ack_l),
    .seg(seg_l), .dp(dp_l), .wela(wela_l), .slot_tick(tick_l)
  );

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_hi (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .load_ack(ack_h),
    .seg(seg_h), .dp(dp_h), .wela(wela_h), .slot_tick(tick_h)
  );

  always #5 clk = ~clk;

  // Digit index derived only from slot_tick pulses since reset.
  always @(negedge clk or posedge rst) begin
    if (rst) bidx <= 0;
    else if (tick_l) bidx <= (bidx + 1) % 4;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d,
                         input logic [3:0] dpv,
                         input logic [3:0] bl);
    din = d; dp_in = dpv; blank_in = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Returns at p=0 of the next slot of digit d.
  task automatic wait_digit(input int d);
    bit found = 0;
    for (int n = 0; n < 80 && !found; n++) begin
      step();
      if (tick_l === 1'b1 && bidx == d) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_digit%0d: no slot_tick in 80 cycles", d);
    end
  endtask

  task automatic test_reset();
    int n;
    bit dark;
    repeat (3) step();
    checks++;
    if (seg_l !== 7'h7F || dp_l !== 1'b1 || wela_l !== 4'hF ||
        ack_l !== 1'b0 || tick_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_lo: seg=%h dp=%b wela=%b ack=%b tick=%b want 7f 1 1111 0 0",
               seg_l, dp_l, wela_l, ack_l, tick_l);
    end
    checks++;
    if (seg_h !== 7'h00 || dp_h !== 1'b0 || wela_h !== 4'h0) begin
      errors++;
      $display("FAIL reset_hi: seg=%h dp=%b wela=%b want 00 0 0000",
               seg_h, dp_h, wela_h);
    end
    rst = 1'b0;
    n = 0;
    dark = 1;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (wela_l !== 4'hF) dark = 0;
      if (tick_l === 1'b1) n = i;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL first_tick: got %0d cycles want 8", n);
    end
    for (int i = 0; i < 24; i++) begin
      step();
      if (wela_l !== 4'hF) dark = 0;
    end
    checks++;
    if (!dark) begin
      errors++;
      $display("FAIL blank_after_reset: anode lit, want none lit");
    end
    do_load(16'h1234, 4'h0, 4'h0);
    wait_digit(1);
    repeat (4) step();
    checks++;
    if (wela_l !== 4'b1101) begin
      errors++;
      $display("FAIL pre_reset_lit: wela=%b want 1101", wela_l);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (wela_l !== 4'hF || seg_l !== 7'h7F || dp_l !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: wela=%b seg=%h dp=%b want 1111 7f 1",
               wela_l, seg_l, dp_l);
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (wela_l !== 4'hF) begin
      errors++;
      $display("FAIL shadow_blanked: wela=%b want 1111", wela_l);
    end
    do_load(16'h1234, 4'h0, 4'h0);
    wait_digit(0);
    step();
    checks++;
    if (wela_l !== 4'hF) begin
      errors++;
      $display("FAIL resume_dead: wela=%b want 1111", wela_l);
    end
    step();
    checks++;
    if (wela_l !== 4'b1110 || seg_l !== 7'b0011001) begin
      errors++;
      $display("FAIL resume_d0: wela=%b seg=%b want 1110 0011001",
               wela_l, seg_l);
    end
  endtask

  task automatic test_scan();
    logic [6:0] es [4] = '{7'b0011001, 7'b0110000,
                           7'b0100100, 7'b1111001};
    logic [3:0] ew;
    logic [6:0] eseg;
    do_load(16'h1234, 4'h0, 4'h0);
    wait_digit(0);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 8; k++) begin
        ew   = (k < 2) ? 4'hF : ~(4'b0001 << d);
        eseg = (k < 2) ? 7'h7F : es[d];
        checks++;
        if (wela_l !== ew || seg_l !== eseg || dp_l !== 1'b1) begin
          errors++;
          $display("FAIL scan d%0d p%0d: wela=%b seg=%b dp=%b want %b %b 1",
                   d, k, wela_l, seg_l, dp_l, ew, eseg);
        end
        if (k == 0) begin
          checks++;
          if (tick_l !== 1'b1) begin
            errors++;
            $display("FAIL tick d%0d: slot_tick=%b want 1", d, tick_l);
          end
        end
        if (k == 1) begin
          checks++;
          if (tick_l !== 1'b0) begin
            errors++;
            $display("FAIL tick_width d%0d: slot_tick=%b want 0", d, tick_l);
          end
        end
        step();
      end
    end
    step();
    step();
    checks++;
    if (wela_l !== 4'b1110 || seg_l !== 7'b0011001) begin
      errors++;
      $display("FAIL scan_wrap: wela=%b seg=%b want 1110 0011001",
               wela_l, seg_l);
    end
  endtask

  task automatic test_atomic_load();
    logic [6:0] ns [4] = '{7'b0100001, 7'b1000110,
                           7'b0000011, 7'b0001000};
    int dd;
    wait_digit(1);
    repeat (3) step();
    din = 16'hABCD;
    load = 1'b1;
    step();
    checks++;
    if (ack_l !== 1'b1) begin
      errors++;
      $display("FAIL load_ack: ack=%b want 1", ack_l);
    end
    load = 1'b0;
    for (int k = 4; k < 8; k++) begin
      checks++;
      if (wela_l !== 4'b1101 || seg_l !== 7'b0110000) begin
        errors++;
        $display("FAIL old_slot p%0d: wela=%b seg=%b want 1101 0110000",
                 k, wela_l, seg_l);
      end
      if (k == 5) begin
        checks++;
        if (ack_l !== 1'b0) begin
          errors++;
          $display("FAIL load_ack_pulse: ack=%b want 0", ack_l);
        end
      end
      step();
    end
    for (int j = 0; j < 4; j++) begin
      dd = (2 + j) % 4;
      step();
      step();
      checks++;
      if (wela_l !== ~(4'b0001 << dd) || seg_l !== ns[dd]) begin
        errors++;
        $display("FAIL new_data d%0d: wela=%b seg=%b want %b %b",
                 dd, wela_l, seg_l, ~(4'b0001 << dd), ns[dd]);
      end
      repeat (6) step();
    end
  endtask

  task automatic test_blank_dp();
    logic [6:0] es [4] = '{7'b0011001, 7'b0110000,
                           7'b0100100, 7'b1111001};
    logic [3:0] ew;
    logic [6:0] eseg;
    logic       edp;
    bit         lit;
    do_load(16'h1234, 4'b0001, 4'b0100);
    wait_digit(0);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 8; k++) begin
        lit  = (k >= 2) && (d != 2);
        ew   = lit ? ~(4'b0001 << d) : 4'hF;
        eseg = lit ? es[d] : 7'h7F;
        edp  = (lit && d == 0) ? 1'b0 : 1'b1;
        checks++;
        if (wela_l !== ew || seg_l !== eseg || dp_l !== edp) begin
          errors++;
          $display("FAIL blank_dp d%0d p%0d: wela=%b seg=%b dp=%b want %b %b %b",
                   d, k, wela_l, seg_l, dp_l, ew, eseg, edp);
        end
        step();
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] s50 [4] = '{7'b1000000, 7'b0010010,
                            7'b1000000, 7'b1000000};
    logic [3:0] m50, m00, ew;
    logic [6:0] eseg;
`ifdef SEG_LZB_EN
    m50 = 4'b0011;
    m00 = 4'b0001;
`else
    m50 = 4'b1111;
    m00 = 4'b1111;
`endif
    do_load(16'h0050, 4'h0, 4'h0);
    wait_digit(0);
    for (int d = 0; d < 4; d++) begin
      step();
      step();
      ew   = m50[d] ? ~(4'b0001 << d) : 4'hF;
      eseg = m50[d] ? s50[d] : 7'h7F;
      checks++;
      if (wela_l !== ew || seg_l !== eseg) begin
        errors++;
        $display("FAIL lzb_0050 d%0d: wela=%b seg=%b want %b %b",
                 d, wela_l, seg_l, ew, eseg);
      end
      repeat (6) step();
    end
    do_load(16'h0000, 4'h0, 4'h0);
    wait_digit(0);
    for (int d = 0; d < 4; d++) begin
      step();
      step();
      ew   = m00[d] ? ~(4'b0001 << d) : 4'hF;
      eseg = m00[d] ? 7'b1000000 : 7'h7F;
      checks++;
      if (wela_l !== ew || seg_l !== eseg) begin
        errors++;
        $display("FAIL lzb_0000 d%0d: wela=%b seg=%b want %b %b",
                 d, wela_l, seg_l, ew, eseg);
      end
      repeat (6) step();
    end
  endtask

  task automatic test_decode_sweep();
    logic [3:0] v4;
    for (int v = 0; v < 16; v++) begin
      v4 = v[3:0];
      do_load({12'h000, v4}, 4'h0, 4'h0);
      wait_digit(0);
      step();
      step();
      checks++;
      if (seg_l !== ~tbl[v] || seg_h !== tbl[v] || wela_h !== 4'b0001) begin
        errors++;
        $display("FAIL decode %h: lo=%b hi=%b wela_hi=%b want %b %b 0001",
                 v4, seg_l, seg_h, wela_h, ~tbl[v], tbl[v]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_atomic_load();
    test_blank_dp();
    test_lzb();
    test_decode_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
